// File: rtl/fpu_issue_ctrl_if.sv
// Datapath interface between the issue controller (master) and the 4-lane butterfly FPU (slave).
// Lane i packs re at [2*DW*i +: DW] and im at [2*DW*i+DW +: DW].
interface fpu_issue_ctrl_if #(
    parameter int DW     = 64,
    parameter int LANES  = 4,
    parameter int MODE_W = 4
);
    localparam int BW = 2 * DW * LANES;

    logic              fpu_en;
    logic [MODE_W-1:0] fpu_mode;
    logic [BW-1:0]     fpu_d_i_a;
    logic [BW-1:0]     fpu_d_i_b;
    logic [BW-1:0]     fpu_d_i_c;
    logic [BW-1:0]     fpu_d_o_a;
    logic [BW-1:0]     fpu_d_o_b;

    modport master (
        output fpu_en,
        output fpu_mode,
        output fpu_d_i_a,
        output fpu_d_i_b,
        output fpu_d_i_c,
        input  fpu_d_o_a,
        input  fpu_d_o_b
    );

    modport slave (
        input  fpu_en,
        input  fpu_mode,
        input  fpu_d_i_a,
        input  fpu_d_i_b,
        input  fpu_d_i_c,
        output fpu_d_o_a,
        output fpu_d_o_b
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// Streams LEN operand vectors from three RAM read ports into the fixed-latency FPU and
// writes the two result vectors back in order; one vector per cycle, no stalls.
module fpu_issue_ctrl #(
    parameter int DW      = 64,
    parameter int LANES   = 4,
    parameter int AW      = 10,
    parameter int MODE_W  = 4,
    parameter int FPU_LAT = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    start,
    input  logic [MODE_W-1:0]       mode,
    input  logic [AW-1:0]           src_a,
    input  logic [AW-1:0]           src_b,
    input  logic [AW-1:0]           src_c,
    input  logic [AW-1:0]           dst_a,
    input  logic [AW-1:0]           dst_b,
    input  logic [AW:0]             len,
    output logic                    busy,
    output logic                    done,

    output logic                    rd_en,
    output logic [AW-1:0]           rd_addr_a,
    output logic [AW-1:0]           rd_addr_b,
    output logic [AW-1:0]           rd_addr_c,
    input  logic [2*DW*LANES-1:0]   rd_data_a,
    input  logic [2*DW*LANES-1:0]   rd_data_b,
    input  logic [2*DW*LANES-1:0]   rd_data_c,

    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr_a,
    output logic [AW-1:0]           wr_addr_b,
    output logic [2*DW*LANES-1:0]   wr_data_a,
    output logic [2*DW*LANES-1:0]   wr_data_b,

    fpu_issue_ctrl_if.master        fpu
);
    localparam int BW    = 2 * DW * LANES;
    localparam int VLD_D = FPU_LAT + 2;
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [AW-1:0]     src_a_q, src_a_d;
    logic [AW-1:0]     src_b_q, src_b_d;
    logic [AW-1:0]     src_c_q, src_c_d;
    logic [AW-1:0]     dst_a_q, dst_a_d;
    logic [AW-1:0]     dst_b_q, dst_b_d;
    logic [AW:0]       len_q, len_d;
    logic [AW:0]       rd_cnt_q, rd_cnt_d;
    logic [AW:0]       wr_cnt_q, wr_cnt_d;
    logic [VLD_D-1:0]  vld_q, vld_d;
    logic [BW-1:0]     d_i_a_q, d_i_a_d;
    logic [BW-1:0]     d_i_b_q, d_i_b_d;
    logic [BW-1:0]     d_i_c_q, d_i_c_d;

    logic              issue_c;
    logic              result_c;

    assign issue_c  = (state_q == S_ISSUE);
    // Tail of the valid pipe marks the cycle the FPU presents the matching result.
    assign result_c = vld_q[VLD_D-1];

    // Operand staging: RAM data arrives one cycle after the read strobe.
    always_comb begin
        vld_d   = {vld_q[VLD_D-2:0], issue_c};
        d_i_a_d = vld_q[0] ? rd_data_a : '0;
        d_i_b_d = vld_q[0] ? rd_data_b : '0;
        d_i_c_d = vld_q[0] ? rd_data_c : '0;
    end

    // Job control FSM and counters.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        src_c_d  = src_c_q;
        dst_a_d  = dst_a_q;
        dst_b_d  = dst_b_q;
        len_d    = len_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = result_c ? wr_cnt_q + CNT_ONE : wr_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d   = mode;
                    src_a_d  = src_a;
                    src_b_d  = src_b;
                    src_c_d  = src_c;
                    dst_a_d  = dst_a;
                    dst_b_d  = dst_b;
                    len_d    = len;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    state_d  = (len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_cnt_d = rd_cnt_q + CNT_ONE;
                if (rd_cnt_q == len_q - CNT_ONE) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (result_c && (wr_cnt_q == len_q - CNT_ONE)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            src_c_q  <= '0;
            dst_a_q  <= '0;
            dst_b_q  <= '0;
            len_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            vld_q    <= '0;
            d_i_a_q  <= '0;
            d_i_b_q  <= '0;
            d_i_c_q  <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            src_c_q  <= src_c_d;
            dst_a_q  <= dst_a_d;
            dst_b_q  <= dst_b_d;
            len_q    <= len_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            vld_q    <= vld_d;
            d_i_a_q  <= d_i_a_d;
            d_i_b_q  <= d_i_b_d;
            d_i_c_q  <= d_i_c_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    assign rd_en     = issue_c;
    assign rd_addr_a = src_a_q + rd_cnt_q[AW-1:0];
    assign rd_addr_b = src_b_q + rd_cnt_q[AW-1:0];
    assign rd_addr_c = src_c_q + rd_cnt_q[AW-1:0];

    assign wr_en     = result_c;
    assign wr_addr_a = dst_a_q + wr_cnt_q[AW-1:0];
    assign wr_addr_b = dst_b_q + wr_cnt_q[AW-1:0];
    assign wr_data_a = fpu.fpu_d_o_a;
    assign wr_data_b = fpu.fpu_d_o_b;

    assign fpu.fpu_en    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign fpu.fpu_mode  = mode_q;
    assign fpu.fpu_d_i_a = d_i_a_q;
    assign fpu.fpu_d_i_b = d_i_b_q;
    assign fpu.fpu_d_i_c = d_i_c_q;
endmodule
